// File: rtl/key_debouncer_pkg.sv
// Shared types and default constants for the pushbutton debouncer.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } kd_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_CNT_WIDTH       = 20;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous level; resets to the idle (high) level.
module sync2 (
    input  logic Clk,
    input  logic Resetn,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Capture the raw input and re-register it to settle metastability.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces an active-low pushbutton into a level, press/release strobes and a toggle.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic KEY_n,
    output logic Pressed,
    output logic Press_pulse,
    output logic Release_pulse,
    output logic Toggle
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic           key_s;
    kd_state_e      state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic           press_evt_s;
    logic           release_evt_s;
    logic           pressed_q;
    logic           press_pulse_q;
    logic           release_pulse_q;
    logic           toggle_q;

    sync2 u_sync2 (
        .Clk     (Clk),
        .Resetn  (Resetn),
        .async_i (KEY_n),
        .sync_o  (key_s)
    );

    // Next-state and counter logic; the counter restarts on every state entry.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_evt_s   = 1'b0;
        release_evt_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!key_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_HELD;
                    cnt_d       = '0;
                    press_evt_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_HELD: begin
                if (key_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_HELD;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    release_evt_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, counter and registered outputs derived from the transition taken.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            toggle_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
            press_pulse_q   <= press_evt_s;
            release_pulse_q <= release_evt_s;
            toggle_q        <= toggle_q ^ press_evt_s;
        end
    end

    assign Pressed       = pressed_q;
    assign Press_pulse   = press_pulse_q;
    assign Release_pulse = release_pulse_q;
    assign Toggle        = toggle_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random key activity vs a run-length model.
module tb_key_debouncer;
    import key_debouncer_pkg::*;

    localparam int D = 8;
    localparam int W = 4;

    logic Clk;
    logic Resetn;
    logic KEY_n;
    logic Pressed;
    logic Press_pulse;
    logic Release_pulse;
    logic Toggle;

    int tests_run;
    int tests_failed;

    key_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(W)) dut (
        .Clk           (Clk),
        .Resetn        (Resetn),
        .KEY_n         (KEY_n),
        .Pressed       (Pressed),
        .Press_pulse   (Press_pulse),
        .Release_pulse (Release_pulse),
        .Toggle        (Toggle)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: a change is accepted once the synchronized key has
    // disagreed with the accepted level on D+1 consecutive clock edges.
    logic m_s1, m_s2, m_acc, m_pp, m_rp, m_tog;
    int   m_run;

    always @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            m_s1 <= 1'b1; m_s2 <= 1'b1; m_acc <= 1'b0;
            m_pp <= 1'b0; m_rp <= 1'b0; m_tog <= 1'b0; m_run <= 0;
        end else begin
            m_s1 <= KEY_n;
            m_s2 <= m_s1;
            m_pp <= 1'b0;
            m_rp <= 1'b0;
            if ((!m_s2) == m_acc) begin
                m_run <= 0;
            end else if (m_run + 1 == D + 1) begin
                m_acc <= ~m_acc;
                m_run <= 0;
                if (!m_acc) begin
                    m_pp  <= 1'b1;
                    m_tog <= ~m_tog;
                end else begin
                    m_rp <= 1'b1;
                end
            end else begin
                m_run <= m_run + 1;
            end
        end
    end

    task automatic tick(input logic key);
        KEY_n = key;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        KEY_n  = 1'b1;
        Resetn = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        KEY_n = 1'b1;
        @(posedge Clk);
        #1;
        Resetn = 1'b0;
        #1;
        tests_run++;
        if ({Pressed, Press_pulse, Release_pulse, Toggle} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000", {Pressed, Press_pulse, Release_pulse, Toggle});
        end
        repeat (2) @(posedge Clk);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1'b1);
            tests_run++;
            if ({Pressed, Press_pulse, Release_pulse, Toggle} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL idle_outputs cycle %0d: got %b expected 0000", i, {Pressed, Press_pulse, Release_pulse, Toggle});
            end
        end
        tests_run++;
        if (dut.state_q !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL idle_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_press();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0);
            tests_run++;
            if ({Pressed, Press_pulse, Release_pulse, Toggle} !== {(i >= D + 2), (i == D + 2), 1'b0, (i >= D + 2)}) begin
                tests_failed++;
                $display("FAIL press edge %0d: got P/PP/RP/T=%b expected %b", i,
                         {Pressed, Press_pulse, Release_pulse, Toggle}, {(i >= D + 2), (i == D + 2), 1'b0, (i >= D + 2)});
            end
        end
    endtask

    task automatic test_release();
        for (int i = 0; i < 15; i++) begin
            tick(1'b1);
            tests_run++;
            if ({Pressed, Press_pulse, Release_pulse, Toggle} !== {(i < D + 2), 1'b0, (i == D + 2), 1'b1}) begin
                tests_failed++;
                $display("FAIL release edge %0d: got P/PP/RP/T=%b expected %b", i,
                         {Pressed, Press_pulse, Release_pulse, Toggle}, {(i < D + 2), 1'b0, (i == D + 2), 1'b1});
            end
        end
        for (int i = 0; i < 15; i++) begin
            tick(1'b0);
            tests_run++;
            if ({Pressed, Press_pulse, Release_pulse, Toggle} !== {(i >= D + 2), (i == D + 2), 1'b0, (i < D + 2)}) begin
                tests_failed++;
                $display("FAIL second_press edge %0d: got P/PP/RP/T=%b expected %b", i,
                         {Pressed, Press_pulse, Release_pulse, Toggle}, {(i >= D + 2), (i == D + 2), 1'b0, (i < D + 2)});
            end
        end
    endtask

    task automatic test_bounce();
        logic [26:0] pat;
        pat = {5'b00000, 2'b11, 5'b00000, 15'h7fff};
        do_reset();
        for (int i = 26; i >= 0; i--) begin
            tick(pat[i]);
            tests_run++;
            if ({Pressed, Press_pulse, Release_pulse, Toggle} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL press_bounce step %0d: got %b expected 0000", 26 - i, {Pressed, Press_pulse, Release_pulse, Toggle});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b0);
        tests_run++;
        if (dut.state_q !== ST_PRESS_WAIT || dut.cnt_q !== 4'd5) begin
            tests_failed++;
            $display("FAIL mid_count: got state %0d cnt %0d expected %0d cnt 5", dut.state_q, dut.cnt_q, ST_PRESS_WAIT);
        end
        Resetn = 1'b0;
        #1;
        tests_run++;
        if ({Pressed, Press_pulse, Release_pulse, Toggle} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %b expected 0000", {Pressed, Press_pulse, Release_pulse, Toggle});
        end
        @(posedge Clk);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1'b0);
            tests_run++;
            if ({Pressed, Press_pulse, Release_pulse} !== {(i >= D + 2), (i == D + 2), 1'b0}) begin
                tests_failed++;
                $display("FAIL after_reset edge %0d: got P/PP/RP=%b expected %b", i,
                         {Pressed, Press_pulse, Release_pulse}, {(i >= D + 2), (i == D + 2), 1'b0});
            end
        end
    endtask

    task automatic test_release_bounce();
        for (int i = 0; i < 23; i++) begin
            tick((i < 3) ? 1'b1 : 1'b0);
            tests_run++;
            if ({Pressed, Press_pulse, Release_pulse} !== 3'b100) begin
                tests_failed++;
                $display("FAIL release_bounce step %0d: got P/PP/RP=%b expected 100", i, {Pressed, Press_pulse, Release_pulse});
            end
        end
    endtask

    task automatic test_random();
        int  remaining;
        int  len;
        logic lvl;
        do_reset();
        remaining = 2000;
        while (remaining > 0) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(D, D + 6) : $urandom_range(1, D + 3);
            for (int k = 0; k < len; k++) begin
                tick(lvl);
                remaining--;
                tests_run++;
                if ({Pressed, Press_pulse, Release_pulse, Toggle} !== {m_acc, m_pp, m_rp, m_tog}) begin
                    tests_failed++;
                    $display("FAIL random cycle %0d: got P/PP/RP/T=%b expected %b", remaining,
                             {Pressed, Press_pulse, Release_pulse, Toggle}, {m_acc, m_pp, m_rp, m_tog});
                end
                tests_run++;
                if (Press_pulse && Release_pulse) begin
                    tests_failed++;
                    $display("FAIL pulse_overlap: got both 1 expected at most one");
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Resetn       = 1'b0;
        KEY_n        = 1'b1;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_reset_mid();
        test_release_bounce();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
